peak_frame_sender: RTL and testbench
====================================

Name: peak_frame_sender

Overview:
Transmit side of the peak-finder sample stream. A producer writes one frame of K signed N-bit samples into the block's buffer. On start, the block streams the frame to the consumer, one sample per ready/send_data handshake, flagging the final sample with last. It sits upstream of the peak finder and feeds its in_data/ready interface.

Parameters:
N, 16, sample width in bits (two's complement)
K, 42, samples per frame (K >= 2)
CW, $clog2(K+1), width of sample counters (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  producer write strobe, accepted only in FILL
wr_data  input  N  sample written at buffer index wr_cnt
wr_full  output  1  high when the buffer holds K samples (ARMED/SEND/DONE)
start  input  1  begin transmission; honoured only in ARMED
abort  input  1  synchronous frame discard, any state
ready  input  1  consumer can accept a sample this cycle
send_data  output  1  out_data valid (sample offered)
out_data  output  N  current sample; 0 whenever send_data=0
last  output  1  high with send_data on sample K-1
done  output  1  one-cycle pulse after the final transfer
busy  output  1  high in SEND
fill_cnt  output  CW  samples currently written (0..K)

Behaviour:
- Reset (rst_n=0, asynchronous): state=FILL, wr_cnt=0, rd_idx=0, and every output goes to 0 immediately, regardless of state. Buffer contents are don't-care.
- Transfer: a transfer occurs on a rising edge where send_data=1 and ready=1.
- Stall: while ready=0, out_data and last hold their values.
- States: FILL, ARMED, SEND, DONE.
- FILL:
  - wr_en=1 writes wr_data to buf[wr_cnt] and increments wr_cnt.
  - The write that makes wr_cnt=K moves the block to ARMED on the same edge, so wr_full=1 from the next cycle.
- ARMED:
  - wr_en is ignored; the buffer is unchanged.
  - start=1 moves the block to SEND with rd_idx=0.
  - Latency: start sampled at edge t gives send_data=1 and out_data=buf[0] after edge t.
- SEND:
  - send_data=1 and out_data=buf[rd_idx]; last=(rd_idx==K-1).
  - A transfer with rd_idx<K-1 increments rd_idx, so the next sample is offered the following cycle. Back-to-back throughput is 1 sample/cycle.
  - A transfer with rd_idx==K-1 moves the block to DONE.
  - start and wr_en are ignored.
- DONE (exactly 1 cycle): done=1, send_data=0, then return to FILL with wr_cnt=0 and rd_idx=0.
- abort=1, any state: next state FILL, wr_cnt=0, rd_idx=0, and all outputs 0 after the edge.
  - abort beats start, wr_en and transfer on the same edge. A transfer coinciding with abort counts as consumed by the consumer, but done is not pulsed.
- start in FILL or SEND: ignored, not queued.
- Samples are sent unmodified, negative values included; filtering is the consumer's job.
- fill_cnt=wr_cnt; it reads K while wr_full=1.
- All outputs except out_data are registered.
  - out_data is a mux of the buffer indexed by the registered rd_idx, gated by send_data.
  - The buffer is not written outside FILL, so out_data is glitch-stable within a cycle.

Decomposition:
- Package peak_stream_pkg:
  - default N and K constants
  - state enum {FILL, ARMED, SEND, DONE}
  - sample_t typedef (signed [N-1:0]), shared with the peak finder
- Sub-module frame_buf: K x N register array, one synchronous write port, one combinational read port. No reset on data.
- FSM, counters and output gating live in peak_frame_sender.

Test Plan (K=4, N=16):
- Basic frame: write 0x0005, 0xFFFD, 0x0064, 0x0007 -> wr_full=1 on the cycle after the 4th write. Pulse start with ready=1 -> out_data 0x0005, 0xFFFD, 0x0064, 0x0007 on 4 consecutive cycles; last only with 0x0007; done pulse on the next cycle; wr_full=0 the cycle after.
- Backpressure: same frame, ready=0 for 3 cycles while 0xFFFD is offered -> out_data holds 0xFFFD and send_data stays 1; sequence resumes with 0x0064; total of 4 transfers.
- Ignored commands: start after 2 writes -> no send_data. A 5th write while ARMED -> fill_cnt stays 4 and frame content is unchanged.
- Abort: abort after 2 transfers -> send_data=0, wr_full=0, fill_cnt=0 next cycle; no done pulse. Abort together with start in ARMED -> FILL, send_data stays 0.
- Async reset mid-SEND: drop rst_n between clock edges -> all outputs 0 immediately. After release, the block is in FILL and accepts a fresh 4-sample frame.
- Back-to-back frames: refill during FILL right after done and start again -> the second frame streams correctly with no stale samples.

Source files
------------

// File: rtl/peak_stream_pkg.sv
// Shared types and defaults for the peak-finder sample stream.
// The frame sender and the peak finder both import this package.
package peak_stream_pkg;

  localparam int N_DEF = 16;
  localparam int K_DEF = 42;

  typedef enum logic [1:0] {
    FILL,
    ARMED,
    SEND,
    DONE
  } state_t;

  typedef logic signed [N_DEF-1:0] sample_t;

endpackage

// File: rtl/peak_stream_if.sv
// Sample stream between the frame sender and the peak finder.
// The sender offers send_data, out_data and last. The consumer answers with ready.
interface peak_stream_if #(
  parameter int N = 16
) ();

  logic         send_data;
  logic [N-1:0] out_data;
  logic         last;
  logic         ready;

  modport master (
    output send_data,
    output out_data,
    output last,
    input  ready
  );

  modport slave (
    input  send_data,
    input  out_data,
    input  last,
    output ready
  );

endinterface

// File: rtl/frame_buf.sv
// K x N frame storage for the frame sender.
// It has one synchronous write port and one combinational read port.
module frame_buf #(
  parameter int N  = 16,
  parameter int K  = 42,
  parameter int AW = $clog2(K+1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [K];

  // NOTE: storage is deliberately left unreset; a frame is always rewritten before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/peak_frame_sender.sv
// Transmit side of the peak-finder stream: buffers one K-sample frame,
// then streams it out with a ready/send_data handshake and flags the final sample.
module peak_frame_sender
  import peak_stream_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int K  = K_DEF,
  localparam int CW = $clog2(K+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [N-1:0]  wr_data,
  output logic          wr_full,
  input  logic          start,
  input  logic          abort,
  peak_stream_if.master tx,
  output logic          done,
  output logic          busy,
  output logic [CW-1:0] fill_cnt
);

  localparam logic [CW-1:0] LAST_IDX = CW'(K-1);

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic          buf_we;
  logic [N-1:0]  rd_sample;

  logic send_q, last_q, done_q, busy_q, full_q;

  frame_buf #(.N(N), .K(K), .AW(CW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_cnt_q),
    .wdata (wr_data),
    .raddr (rd_idx_q),
    .rdata (rd_sample)
  );

  // NOTE: every signal gets a default value first, so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_idx_d = rd_idx_q;
    buf_we   = 1'b0;

    unique case (state_q)
      FILL: begin
        if (wr_en) begin
          buf_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_IDX) state_d = ARMED;
        end
      end
      ARMED: begin
        if (start) begin
          state_d  = SEND;
          rd_idx_d = '0;
        end
      end
      SEND: begin
        // send_data is always high in SEND, so ready alone marks a transfer.
        if (tx.ready) begin
          if (rd_idx_q == LAST_IDX) state_d = DONE;
          else                      rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d  = FILL;
        wr_cnt_d = '0;
        rd_idx_d = '0;
      end
      default: state_d = FILL;
    endcase

    // Abort takes priority over any write, start or transfer on the same edge.
    if (abort) begin
      state_d  = FILL;
      wr_cnt_d = '0;
      rd_idx_d = '0;
      buf_we   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
      send_q   <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_idx_q <= rd_idx_d;
      send_q   <= (state_d == SEND);
      last_q   <= (state_d == SEND) && (rd_idx_d == LAST_IDX);
      done_q   <= (state_d == DONE);
      busy_q   <= (state_d == SEND);
      full_q   <= (state_d != FILL);
    end
  end

  assign tx.send_data = send_q;
  assign tx.last      = last_q;
  assign tx.out_data  = send_q ? rd_sample : '0;
  assign done         = done_q;
  assign busy         = busy_q;
  assign wr_full      = full_q;
  assign fill_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_peak_frame_sender.sv
// Directed bench for peak_frame_sender with K=4 and N=16.
// Expected values are hand-computed from the frame contents written by the bench.
module tb_peak_frame_sender;

  localparam int N = 16;
  localparam int K = 4;

  typedef logic [K-1:0][N-1:0] frame_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [N-1:0] wr_data;
  logic         wr_full;
  logic         start;
  logic         abort;
  logic         done;
  logic         busy;
  logic [2:0]   fill_cnt;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  peak_stream_if #(.N(N)) stream ();

  peak_frame_sender #(.N(N), .K(K)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_full  (wr_full),
    .start    (start),
    .abort    (abort),
    .tx       (stream),
    .done     (done),
    .busy     (busy),
    .fill_cnt (fill_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && stream.send_data && stream.ready) xfers++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input frame_t f);
    for (int i = 0; i < K; i++) begin
      wr_en   = 1'b1;
      wr_data = f[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expects sample 0 to be on offer already and ready held high.
  task automatic expect_frame(input string tag, input frame_t f);
    for (int i = 0; i < K; i++) begin
      check($sformatf("%s send[%0d]", tag, i), 32'(stream.send_data), 32'd1);
      check($sformatf("%s data[%0d]", tag, i), 32'(stream.out_data), 32'(f[i]));
      check($sformatf("%s last[%0d]", tag, i), 32'(stream.last), 32'(i == K-1));
      tick();
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " send_off"}, 32'(stream.send_data), 32'd0);
    check({tag, " done_full"}, 32'(wr_full), 32'd1);
    tick();
    check({tag, " done_drop"}, 32'(done), 32'd0);
    check({tag, " full_drop"}, 32'(wr_full), 32'd0);
    check({tag, " fill_zero"}, 32'(fill_cnt), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " send"}, 32'(stream.send_data), 32'd0);
    check({tag, " data"}, 32'(stream.out_data), 32'd0);
    check({tag, " last"}, 32'(stream.last), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " full"}, 32'(wr_full), 32'd0);
    check({tag, " fill"}, 32'(fill_cnt), 32'd0);
  endtask

  frame_t fa, fb, fc;
  int     x0;

  initial begin
    fa = {16'h0007, 16'h0064, 16'hFFFD, 16'h0005};
    fb = {16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000};
    fc = {16'h1357, 16'h0000, 16'hF00F, 16'h0A0A};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; abort = 1'b0;
    stream.ready = 1'b1;
    #1;
    check_idle("reset");
    #16 rst_n = 1'b1;
    tick();

    // Basic frame
    wr_en = 1'b1; wr_data = fa[0]; tick();
    wr_data = fa[1]; tick();
    wr_data = fa[2]; tick();
    check("fill3_cnt", 32'(fill_cnt), 32'd3);
    check("fill3_full", 32'(wr_full), 32'd0);
    wr_data = fa[3]; tick();
    wr_en = 1'b0;
    check("armed_full", 32'(wr_full), 32'd1);
    check("armed_cnt", 32'(fill_cnt), 32'd4);
    check("armed_send", 32'(stream.send_data), 32'd0);
    pulse_start();
    check("basic busy", 32'(busy), 32'd1);
    expect_frame("basic", fa);

    // Backpressure while the second sample is offered
    write_frame(fa);
    x0 = xfers;
    pulse_start();
    tick();
    stream.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall data[%0d]", i), 32'(stream.out_data), 32'h0000FFFD);
      check($sformatf("stall send[%0d]", i), 32'(stream.send_data), 32'd1);
      check($sformatf("stall last[%0d]", i), 32'(stream.last), 32'd0);
      tick();
    end
    stream.ready = 1'b1;
    tick();
    check("resume data2", 32'(stream.out_data), 32'h00000064);
    tick();
    check("resume data3", 32'(stream.out_data), 32'h00000007);
    check("resume last", 32'(stream.last), 32'd1);
    tick();
    check("bp done", 32'(done), 32'd1);
    check("bp xfers", 32'(xfers - x0), 32'd4);
    tick();

    // A start after only two writes is ignored
    wr_en = 1'b1; wr_data = fb[0]; tick();
    wr_data = fb[1]; tick();
    wr_en = 1'b0;
    pulse_start();
    check("early start send", 32'(stream.send_data), 32'd0);
    check("early start cnt", 32'(fill_cnt), 32'd2);
    tick();
    check("early start send2", 32'(stream.send_data), 32'd0);
    wr_en = 1'b1; wr_data = fb[2]; tick();
    wr_data = fb[3]; tick();
    wr_data = 16'h1234; tick();
    wr_en = 1'b0;
    check("extra write cnt", 32'(fill_cnt), 32'd4);
    check("extra write full", 32'(wr_full), 32'd1);
    pulse_start();
    expect_frame("ignored", fb);

    // Abort after two transfers
    write_frame(fb);
    pulse_start();
    tick();
    tick();
    check("pre-abort data", 32'(stream.out_data), 32'h00000001);
    abort = 1'b1; tick(); abort = 1'b0;
    check_idle("abort");
    tick();
    check("abort no done", 32'(done), 32'd0);

    // Abort together with start while ARMED
    write_frame(fa);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    check_idle("abort_start");
    tick();
    check("abort_start send2", 32'(stream.send_data), 32'd0);

    // Async reset mid-SEND
    write_frame(fc);
    pulse_start();
    tick();
    check("pre-reset send", 32'(stream.send_data), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async rst");
    #2 rst_n = 1'b1;
    tick();
    check_idle("post rst");
    write_frame(fa);
    pulse_start();
    expect_frame("after rst", fa);

    // Back-to-back frames: refill straight after done
    write_frame(fc);
    pulse_start();
    expect_frame("b2b1", fc);
    write_frame(fb);
    pulse_start();
    expect_frame("b2b2", fb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
